// File: rtl/instr_arbiter.sv
// Round-robin arbiter sharing one instruction bus among four requesters. NOPs are dropped in IDLE; other winners issue after one cycle.
// The registered output holds under out_ready=0; acks fire only on handshake or on a NOP drop.
module instr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 16,
  parameter int OPW  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*IW-1:0] instr_flat,
  input  logic              is_death,
  output logic [NREQ-1:0]   ack,
  output logic              out_valid,
  output logic [IW-1:0]     out_instr,
  output logic [1:0]        out_src,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       issue_count
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t          state;
  logic [1:0]      rr_last;
  logic [1:0]      win;
  logic [1:0]      cand;
  logic            win_vld;
  logic            win_nop;
  logic [NREQ-1:0] elig;
  logic [IW-1:0]   win_instr;

  always_comb begin
    elig    = req & (is_death ? NREQ'(1) : {NREQ{1'b1}});
    win_vld = 1'b0;
    win     = rr_last;
    cand    = rr_last;
    // Search starts just after the last winner so every requester gets a turn.
    for (int k = 1; k <= NREQ; k++) begin
      cand = rr_last + 2'(k);
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
    win_instr = instr_flat[win*IW +: IW];
    win_nop   = (win_instr[IW-1 -: OPW] == '0);

    ack = '0;
    if (!reset) begin
      if (state == IDLE && win_vld && win_nop)
        ack[win] = 1'b1;
      else if (state == ISSUE && out_ready)
        ack[out_src] = 1'b1;
    end
  end

  assign busy = (state == ISSUE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_last     <= 2'd3;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_src     <= 2'd0;
      issue_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            rr_last <= win;
            if (!win_nop) begin
              out_instr <= win_instr;
              out_src   <= win;
              out_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            issue_count <= issue_count + 16'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
